// File: rtl/cla_sum_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// S1 holds bit/group generate-propagate terms, S2 holds the finished result.
module cla_sum_pipe #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = WIDTH / GROUP;
   localparam int LG = $clog2(NG);

   // ---------------- stage 0: operand conditioning ----------------
   logic [WIDTH-1:0]  b_x;
   logic [WIDTH-1:0]  p_x;
   logic [WIDTH-1:0]  g_x;
   logic              c0_x;
   logic [2*NG-1:0]   gp_x;
   logic              gg;
   logic              pp;

   assign b_x  = b ^ {WIDTH{sub}};
   assign p_x  = a ^ b_x;
   assign g_x  = a & b_x;
   assign c0_x = sub | cin;

   // Per-group lookahead generate/propagate, packed {G,P} per group
   always_comb begin
      gp_x = '0;
      gg   = 1'b0;
      pp   = 1'b0;
      for (int k = 0; k < NG; k++) begin
         gg = g_x[k*GROUP];
         pp = p_x[k*GROUP];
         for (int i = 1; i < GROUP; i++) begin
            gg = g_x[k*GROUP+i] | (p_x[k*GROUP+i] & gg);
            pp = pp & p_x[k*GROUP+i];
         end
         gp_x[2*k+1] = gg;
         gp_x[2*k]   = pp;
      end
   end

   // ---------------- pipeline registers ----------------
   logic              s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0]  s1_p_q, s1_p_d;
   logic [WIDTH-1:0]  s1_g_q, s1_g_d;
   logic              s1_c0_q, s1_c0_d;
   logic [2*NG-1:0]   s1_gp_q, s1_gp_d;

   logic              s2_vld_q, s2_vld_d;
   logic [WIDTH-1:0]  s2_sum_q, s2_sum_d;
   logic              s2_cout_q, s2_cout_d;
   logic              s2_ovf_q, s2_ovf_d;
   logic              s2_zero_q, s2_zero_d;

   // ---------------- handshake ----------------
   logic s2_adv;
   logic s1_adv;
   logic accept;
   logic s2_load;

   assign s2_adv   = ~s2_vld_q | out_ready;
   assign s1_adv   = ~s1_vld_q | s2_adv;
   assign in_ready = s1_adv;
   assign accept   = in_valid & s1_adv;
   assign s2_load  = s2_adv & s1_vld_q;

   // ---------------- stage 1: prefix carry network ----------------
   logic [2*NG-1:0]  pf;
   logic [2*NG-1:0]  nx;
   logic [NG-1:0]    gc;
   logic [WIDTH-1:0] cy;
   logic             cc;
   logic [WIDTH-1:0] sum_x;
   logic             cout_x;
   logic             ovf_x;
   logic             zero_x;

   // Kogge-Stone prefix over the group {G,P} pairs
   always_comb begin
      pf = s1_gp_q;
      nx = s1_gp_q;
      for (int l = 0; l < LG; l++) begin
         nx = pf;
         for (int k = 0; k < NG; k++) begin
            int d;
            int src;
            d   = 1 << l;
            src = (k >= d) ? (k - d) : k;
            if (k >= d) begin
               nx[2*k+1] = pf[2*k+1] | (pf[2*k] & pf[2*src+1]);
               nx[2*k]   = pf[2*k] & pf[2*src];
            end
         end
         pf = nx;
      end
   end

   // Group carries, then ripple inside each group from its carry-in
   always_comb begin
      gc    = '0;
      gc[0] = s1_c0_q;
      for (int k = 1; k < NG; k++) begin
         gc[k] = pf[2*(k-1)+1] | (pf[2*(k-1)] & s1_c0_q);
      end
      cy = '0;
      cc = 1'b0;
      for (int k = 0; k < NG; k++) begin
         cc = gc[k];
         for (int i = 0; i < GROUP; i++) begin
            cy[k*GROUP+i] = cc;
            cc = s1_g_q[k*GROUP+i] | (s1_p_q[k*GROUP+i] & cc);
         end
      end
      cout_x = cc;
      sum_x  = s1_p_q ^ cy;
      ovf_x  = cy[WIDTH-1] ^ cc;
      zero_x = ~|sum_x;
   end

   // Next-state selection for both stages
   always_comb begin
      s1_vld_d  = s1_adv ? in_valid : s1_vld_q;
      s1_p_d    = accept ? p_x  : s1_p_q;
      s1_g_d    = accept ? g_x  : s1_g_q;
      s1_c0_d   = accept ? c0_x : s1_c0_q;
      s1_gp_d   = accept ? gp_x : s1_gp_q;
      s2_vld_d  = s2_adv ? s1_vld_q : s2_vld_q;
      s2_sum_d  = s2_load ? sum_x  : s2_sum_q;
      s2_cout_d = s2_load ? cout_x : s2_cout_q;
      s2_ovf_d  = s2_load ? ovf_x  : s2_ovf_q;
      s2_zero_d = s2_load ? zero_x : s2_zero_q;
   end

   // Stage registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_p_q    <= '0;
         s1_g_q    <= '0;
         s1_c0_q   <= 1'b0;
         s1_gp_q   <= '0;
         s2_vld_q  <= 1'b0;
         s2_sum_q  <= '0;
         s2_cout_q <= 1'b0;
         s2_ovf_q  <= 1'b0;
         s2_zero_q <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_p_q    <= s1_p_d;
         s1_g_q    <= s1_g_d;
         s1_c0_q   <= s1_c0_d;
         s1_gp_q   <= s1_gp_d;
         s2_vld_q  <= s2_vld_d;
         s2_sum_q  <= s2_sum_d;
         s2_cout_q <= s2_cout_d;
         s2_ovf_q  <= s2_ovf_d;
         s2_zero_q <= s2_zero_d;
      end
   end

   assign out_valid = s2_vld_q;
   assign sum       = s2_sum_q;
   assign cout      = s2_cout_q;
   assign ovf       = s2_ovf_q;
   assign zero      = s2_zero_q;

endmodule
